// File: rtl/uart_word_receiver.sv
// uart_word_receiver: 8N1 UART byte decoder that packs NUM_BYTES bytes into one
// little-endian word and delivers it with a single-cycle valid pulse.
// A partial word is dropped on an inter-byte timeout or on a framing error.
// Optional feature macro: WORD_CHECKSUM_EN. When it is defined, an XOR
// checksum byte must follow the data bytes before the word is delivered.
module uart_word_receiver #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter int unsigned NUM_BYTES    = 4,
  parameter int unsigned TIMEOUT_CLKS = 250000
) (
  input  logic                     CLK_25MHZ,
  input  logic                     RSTN,
  input  logic                     i_Rx_Serial,
  output logic [8*NUM_BYTES-1:0]   o_Rx_Word,
  output logic                     o_Rx_DV,
  output logic                     o_Frame_Err,
  output logic                     o_Timeout,
  output logic                     o_Chk_Err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT_CLKS - 1);
`ifdef WORD_CHECKSUM_EN
  localparam logic [3:0]      ChkIdx   = 4'(NUM_BYTES);
`else
  localparam logic [3:0]      DataLast = 4'(NUM_BYTES - 1);
`endif

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e                 r_state;
  logic                   r_rx_meta;
  logic                   r_rx_sync;
  logic [CntW-1:0]        r_cnt;
  logic [2:0]             r_bit;
  logic [7:0]             r_shift;
  logic [3:0]             r_idx;
  logic [TmoW-1:0]        r_tmo;
  logic [8*NUM_BYTES-1:0] r_shadow;
  logic [8*NUM_BYTES-1:0] r_word;
  logic                   r_dv;
  logic                   r_frame_err;
  logic                   r_timeout;
`ifdef WORD_CHECKSUM_EN
  logic [7:0]             r_xor;
  logic                   r_chk_err;
`else
  logic [8*NUM_BYTES-1:0] w_word_full;
`endif

  // Two-flop synchroniser on the raw line; presets to idle-high.
  always_ff @(posedge CLK_25MHZ or negedge RSTN) begin
    if (!RSTN) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= i_Rx_Serial;
      r_rx_sync <= r_rx_meta;
    end
  end

`ifndef WORD_CHECKSUM_EN
  // Completed word: staged bytes with the final byte dropped into the top slot.
  always_comb begin
    w_word_full = r_shadow;
    w_word_full[8*(NUM_BYTES-1) +: 8] = r_shift;
  end
`endif

  // Bit FSM, byte packing, timeout and registered output pulses.
  always_ff @(posedge CLK_25MHZ or negedge RSTN) begin
    if (!RSTN) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_idx       <= '0;
      r_tmo       <= '0;
      r_shadow    <= '0;
      r_word      <= '0;
      r_dv        <= 1'b0;
      r_frame_err <= 1'b0;
      r_timeout   <= 1'b0;
`ifdef WORD_CHECKSUM_EN
      r_xor       <= '0;
      r_chk_err   <= 1'b0;
`endif
    end else begin
      r_dv        <= 1'b0;
      r_frame_err <= 1'b0;
      r_timeout   <= 1'b0;
`ifdef WORD_CHECKSUM_EN
      r_chk_err   <= 1'b0;
`endif
      unique case (r_state)
        StIdle: begin
          if (!r_rx_sync) begin
            r_state <= StStart;
            r_cnt   <= '0;
            r_tmo   <= '0;
          end else if (r_idx != '0) begin
            if (r_tmo == TmoLast) begin
              r_idx     <= '0;
              r_tmo     <= '0;
              r_timeout <= 1'b1;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end else begin
            r_tmo <= '0;
          end
        end
        StStart: begin
          if (r_cnt == HalfLast) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= r_rx_sync ? StIdle : StData;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StData: begin
          if (r_cnt == BitLast) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_sync, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
            if (r_bit == 3'd7) r_state <= StStop;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StStop: begin
          if (r_cnt == BitLast) begin
            r_cnt   <= '0;
            r_state <= StIdle;
            if (!r_rx_sync) begin
              r_frame_err <= 1'b1;
              r_idx       <= '0;
`ifdef WORD_CHECKSUM_EN
            end else if (r_idx == ChkIdx) begin
              r_idx <= '0;
              if (r_shift == r_xor) begin
                r_word <= r_shadow;
                r_dv   <= 1'b1;
              end else begin
                r_chk_err <= 1'b1;
              end
            end else begin
              for (int k = 0; k < int'(NUM_BYTES); k++) begin
                if (r_idx == 4'(k)) r_shadow[8*k +: 8] <= r_shift;
              end
              r_xor <= (r_idx == '0) ? r_shift : (r_xor ^ r_shift);
              r_idx <= r_idx + 1'b1;
            end
`else
            end else if (r_idx == DataLast) begin
              r_word <= w_word_full;
              r_dv   <= 1'b1;
              r_idx  <= '0;
            end else begin
              for (int k = 0; k < int'(NUM_BYTES); k++) begin
                if (r_idx == 4'(k)) r_shadow[8*k +: 8] <= r_shift;
              end
              r_idx <= r_idx + 1'b1;
            end
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_Rx_Word   = r_word;
  assign o_Rx_DV     = r_dv;
  assign o_Frame_Err = r_frame_err;
  assign o_Timeout   = r_timeout;
`ifdef WORD_CHECKSUM_EN
  assign o_Chk_Err   = r_chk_err;
`else
  assign o_Chk_Err   = 1'b0;
`endif

endmodule
